oled_text_sequencer: RTL and testbench

OLED_TEXT_SEQUENCER -- requirements
Module: oled_text_sequencer

---
 rtl/oled_text_sequencer_if.sv | 34 +++
 rtl/oled_text_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_oled_text_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_text_sequencer_if.sv
// Character input, OLED controller write/update handshakes and status for oled_text_sequencer.
// The slave modport is the sequencer; the master modport is its environment (source + controller).
`timescale 1ns/1ps
interface oled_text_sequencer_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CUR_W  = 6;

  logic [DATA_W-1:0] char_data;
  logic              char_valid;
  logic              char_ready;
  logic              flush;
  logic              write_start;
  logic [DATA_W-1:0] write_ascii_data;
  logic [ADDR_W-1:0] write_base_addr;
  logic              write_ready;
  logic              update_start;
  logic              update_clear;
  logic              update_ready;
  logic [CUR_W-1:0]  cursor;
  logic              busy;

  modport master (
    output char_data, char_valid, flush, write_ready, update_ready,
    input  char_ready, write_start, write_ascii_data, write_base_addr,
           update_start, update_clear, cursor, busy
  );

  modport slave (
    input  char_data, char_valid, flush, write_ready, update_ready,
    output char_ready, write_start, write_ascii_data, write_base_addr,
           update_start, update_clear, cursor, busy
  );
endinterface

// File: rtl/oled_text_sequencer.sv
// Turns an ASCII stream into character writes and display updates for a 4x16 OLED text controller.
// Handles cursor motion, newline/CR/backspace/form-feed, and merged flush requests.
`timescale 1ns/1ps
module oled_text_sequencer #(
  parameter bit AUTO_UPDATE = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  oled_text_sequencer_if.slave bus
);
  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [5:0] LAST_CELL = 6'h3F;

  typedef enum logic [2:0] {
    IDLE, WRITE, WRITE_WAIT, UPD, UPD_WAIT, FILL, FILL_WAIT
  } state_t;

  state_t     state;
  logic       flush_pending;
  logic       auto_pending;
  logic       first_wait;
  logic       wrap_after;
  logic [5:0] cursor_after;
  logic [5:0] fill_idx;

  logic accept_c;
  logic printable_c;
  assign accept_c    = bus.char_valid & bus.char_ready;
  assign printable_c = (bus.char_data >= 8'h20) && (bus.char_data <= 8'h7E);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      flush_pending        <= 1'b0;
      auto_pending         <= 1'b0;
      first_wait           <= 1'b0;
      wrap_after           <= 1'b0;
      cursor_after         <= 6'd0;
      fill_idx             <= 6'd0;
      bus.char_ready       <= 1'b0;
      bus.write_start      <= 1'b0;
      bus.write_ascii_data <= 8'd0;
      bus.write_base_addr  <= 9'd0;
      bus.update_start     <= 1'b0;
      bus.update_clear     <= 1'b0;
      bus.cursor           <= 6'd0;
      bus.busy             <= 1'b0;
    end else begin
      bus.write_start  <= 1'b0;
      bus.update_start <= 1'b0;
      bus.update_clear <= 1'b0;
      if (bus.flush) flush_pending <= 1'b1;

      case (state)
        IDLE: begin
          // Pending updates win over new characters.
          if (flush_pending || auto_pending) begin
            state          <= UPD;
            bus.busy       <= 1'b1;
            bus.char_ready <= 1'b0;
          end else if (accept_c) begin
            bus.char_ready <= ~bus.flush;
            if (printable_c) begin
              state                <= WRITE;
              bus.busy             <= 1'b1;
              bus.char_ready       <= 1'b0;
              bus.write_ascii_data <= bus.char_data;
              bus.write_base_addr  <= {bus.cursor, 3'b000};
              cursor_after         <= bus.cursor + 6'd1;
              wrap_after           <= (bus.cursor == LAST_CELL);
            end else begin
              case (bus.char_data)
                8'h0A: begin
                  bus.cursor <= {bus.cursor[5:4] + 2'd1, 4'd0};
                  if (AUTO_UPDATE) begin
                    auto_pending   <= 1'b1;
                    bus.char_ready <= 1'b0;
                  end
                end
                8'h0D: bus.cursor <= {bus.cursor[5:4], 4'd0};
                8'h08: begin
                  if (bus.cursor[3:0] != 4'd0) begin
                    state                <= WRITE;
                    bus.busy             <= 1'b1;
                    bus.char_ready       <= 1'b0;
                    bus.write_ascii_data <= SPACE;
                    bus.write_base_addr  <= {bus.cursor - 6'd1, 3'b000};
                    cursor_after         <= bus.cursor - 6'd1;
                    wrap_after           <= 1'b0;
                  end
                end
                8'h0C: begin
                  state          <= FILL;
                  bus.busy       <= 1'b1;
                  bus.char_ready <= 1'b0;
                  fill_idx       <= 6'd0;
                end
                default: ;
              endcase
            end
          end else begin
            bus.char_ready <= ~bus.flush;
          end
        end

        WRITE: begin
          if (bus.write_ready) begin
            bus.write_start <= 1'b1;
            first_wait      <= 1'b1;
            state           <= WRITE_WAIT;
          end
        end

        // write_ready is stale during the pulse cycle, so it is ignored once.
        WRITE_WAIT: begin
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (bus.write_ready) begin
            bus.cursor <= cursor_after;
            state      <= IDLE;
            bus.busy   <= 1'b0;
            if (AUTO_UPDATE && wrap_after) begin
              auto_pending   <= 1'b1;
              bus.char_ready <= 1'b0;
            end else begin
              bus.char_ready <= ~(bus.flush | flush_pending);
            end
          end
        end

        FILL: begin
          if (bus.write_ready) begin
            bus.write_start      <= 1'b1;
            bus.write_ascii_data <= SPACE;
            bus.write_base_addr  <= {fill_idx, 3'b000};
            first_wait           <= 1'b1;
            state                <= FILL_WAIT;
          end
        end

        FILL_WAIT: begin
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (bus.write_ready) begin
            if (fill_idx == LAST_CELL) begin
              bus.cursor <= 6'd0;
              state      <= IDLE;
              bus.busy   <= 1'b0;
              if (AUTO_UPDATE) begin
                auto_pending   <= 1'b1;
                bus.char_ready <= 1'b0;
              end else begin
                bus.char_ready <= ~(bus.flush | flush_pending);
              end
            end else begin
              fill_idx <= fill_idx + 6'd1;
              state    <= FILL;
            end
          end
        end

        // A flush arriving in the launch cycle requests a further update.
        UPD: begin
          if (bus.update_ready) begin
            bus.update_start <= 1'b1;
            flush_pending    <= bus.flush;
            auto_pending     <= 1'b0;
            first_wait       <= 1'b1;
            state            <= UPD_WAIT;
          end
        end

        UPD_WAIT: begin
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (bus.update_ready) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.char_ready <= ~(bus.flush | flush_pending);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oled_text_sequencer.sv
// Scoreboard bench for oled_text_sequencer: a text-terminal model predicts writes/updates,
// a monitor pops and compares every start pulse, and a responder plays the OLED controller.
`timescale 1ns/1ps
module tb_oled_text_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oled_text_sequencer_if bus();

  oled_text_sequencer #(.AUTO_UPDATE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         is_upd;
    logic [7:0] data;
    logic [8:0] addr;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  n_wr   = 0;
  int  n_upd  = 0;
  int  row    = 0;
  int  col    = 0;

  // Controller responder: ready drops after a start, returns after 1..4 cycles.
  logic wr_rdy_q  = 1'b1;
  logic upd_rdy_q = 1'b1;
  logic wr_gate   = 1'b1;
  int   wr_cnt    = 0;
  int   upd_cnt   = 0;
  assign bus.write_ready  = wr_rdy_q & wr_gate;
  assign bus.update_ready = upd_rdy_q;

  always @(posedge clk) begin
    if (bus.write_start) begin
      wr_rdy_q <= 1'b0;
      wr_cnt   <= int'($urandom_range(1, 4));
    end else if (wr_cnt > 0) begin
      wr_cnt <= wr_cnt - 1;
      if (wr_cnt == 1) wr_rdy_q <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (bus.update_start) begin
      upd_rdy_q <= 1'b0;
      upd_cnt   <= int'($urandom_range(1, 4));
    end else if (upd_cnt > 0) begin
      upd_cnt <= upd_cnt - 1;
      if (upd_cnt == 1) upd_rdy_q <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [5:0] exp_cursor();
    return 6'(row * 16 + col);
  endfunction

  task automatic push_w(input logic [7:0] d);
    ev_t e;
    e.is_upd = 1'b0;
    e.data   = d;
    e.addr   = 9'(row * 128 + col * 8);
    exp_q.push_back(e);
  endtask

  task automatic push_u();
    ev_t e;
    e.is_upd = 1'b1;
    e.data   = 8'd0;
    e.addr   = 9'd0;
    exp_q.push_back(e);
  endtask

  // Text-terminal reference: what a 4x16 screen does with each code.
  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_w(c);
      col++;
      if (col == 16) begin
        col = 0;
        row = (row + 1) % 4;
        if (row == 0) push_u();
      end
    end else if (c == 8'h0A) begin
      col = 0;
      row = (row + 1) % 4;
      push_u();
    end else if (c == 8'h0D) begin
      col = 0;
    end else if (c == 8'h08) begin
      if (col > 0) begin
        col--;
        push_w(8'h20);
      end
    end else if (c == 8'h0C) begin
      for (int i = 0; i < 64; i++) begin
        row = i / 16;
        col = i % 16;
        push_w(8'h20);
      end
      row = 0;
      col = 0;
      push_u();
    end
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.write_start && bus.update_start) fail("pulse_overlap");
        if (bus.write_start) begin
          n_wr++;
          if (exp_q.size() == 0) fail("unexpected_write");
          else begin
            e = exp_q.pop_front();
            check("write_kind", 32'(bus.update_start), 32'(e.is_upd));
            if (e.is_upd) fail("write_instead_of_update");
            check("write_data", 32'(bus.write_ascii_data), 32'(e.data));
            check("write_addr", 32'(bus.write_base_addr), 32'(e.addr));
          end
        end else if (bus.update_start) begin
          n_upd++;
          if (exp_q.size() == 0) fail("unexpected_update");
          else begin
            e = exp_q.pop_front();
            if (!e.is_upd) fail("update_instead_of_write");
            check("update_clear", 32'(bus.update_clear), 32'd0);
          end
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_char_ready"}, 32'(bus.char_ready), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_write_start"}, 32'(bus.write_start), 32'd0);
    check({tag, "_update_start"}, 32'(bus.update_start), 32'd0);
    check({tag, "_update_clear"}, 32'(bus.update_clear), 32'd0);
    check({tag, "_write_data"}, 32'(bus.write_ascii_data), 32'd0);
    check({tag, "_write_addr"}, 32'(bus.write_base_addr), 32'd0);
    check({tag, "_cursor"}, 32'(bus.cursor), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    row = 0;
    col = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    check("char_ready_after_rst", 32'(bus.char_ready), 32'd1);
  endtask

  task automatic send_char(input logic [7:0] c, input logic with_flush);
    int cyc;
    model_char(c);
    if (with_flush) push_u();
    @(negedge clk);
    bus.char_data  = c;
    bus.char_valid = 1'b1;
    cyc = 0;
    while (!bus.char_ready && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.char_ready) begin
      fail("send_timeout");
      bus.char_valid = 1'b0;
    end else begin
      bus.flush = with_flush;
      @(posedge clk);
      #1;
      bus.char_valid = 1'b0;
      bus.flush      = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy && bus.char_ready) done = 1'b1;
    end
    if (!done) fail({name, "_idle_timeout"});
  endtask

  initial begin
    int bw, bu;
    bit found;
    logic [7:0] ctl [8];
    logic [7:0] c;
    ctl = '{8'h0A, 8'h0D, 8'h08, 8'h08, 8'h0C, 8'h00, 8'h1B, 8'h7F};
    bus.char_data  = 8'd0;
    bus.char_valid = 1'b0;
    bus.flush      = 1'b0;
    fork
      monitor();
    join_none

    do_reset();

    // 'A' at (0,0), controller ready only after 3 cycles.
    bw = n_wr;
    wr_gate = 1'b0;
    send_char(8'h41, 1'b0);
    repeat (3) @(negedge clk);
    check("a_no_early_write", 32'(n_wr - bw), 32'd0);
    wr_gate = 1'b1;
    wait_idle("a");
    check("a_write_count", 32'(n_wr - bw), 32'd1);
    check("a_cursor", 32'(bus.cursor), 32'h01);

    // 17 characters wrap into row 1.
    do_reset();
    for (int i = 0; i < 17; i++) send_char(8'(8'h61 + i), 1'b0);
    wait_idle("seq17");
    check("seq17_cursor", 32'(bus.cursor), 32'h11);

    // Screen wrap from (3,15).
    do_reset();
    repeat (3) send_char(8'h0A, 1'b0);
    for (int i = 0; i < 15; i++) send_char(8'h30, 1'b0);
    wait_idle("pre_wrap");
    check("pre_wrap_cursor", 32'(bus.cursor), 32'h3F);
    bu = n_upd;
    send_char(8'h5A, 1'b0);
    wait_idle("wrap");
    check("wrap_updates", 32'(n_upd - bu), 32'd1);
    check("wrap_cursor", 32'(bus.cursor), 32'h00);

    // Form feed from a non-home cursor.
    send_char(8'h51, 1'b0);
    wait_idle("pre_ff");
    bw = n_wr;
    bu = n_upd;
    send_char(8'h0C, 1'b0);
    wait_idle("ff");
    check("ff_writes", 32'(n_wr - bw), 32'd64);
    check("ff_updates", 32'(n_upd - bu), 32'd1);
    check("ff_cursor", 32'(bus.cursor), 32'h00);

    // Backspace at col 0 and mid-row.
    do_reset();
    repeat (2) send_char(8'h0A, 1'b0);
    wait_idle("pre_bs");
    bw = n_wr;
    send_char(8'h08, 1'b0);
    wait_idle("bs0");
    check("bs0_writes", 32'(n_wr - bw), 32'd0);
    check("bs0_cursor", 32'(bus.cursor), 32'h20);
    for (int i = 0; i < 5; i++) send_char(8'h62, 1'b0);
    send_char(8'h08, 1'b0);
    wait_idle("bs5");
    check("bs5_cursor", 32'(bus.cursor), 32'h24);

    // Carriage return and a discarded code.
    bw = n_wr;
    bu = n_upd;
    send_char(8'h0D, 1'b0);
    send_char(8'h1B, 1'b0);
    wait_idle("cr");
    check("cr_cursor", 32'(bus.cursor), 32'h20);
    check("cr_no_traffic", 32'(n_wr - bw + n_upd - bu), 32'd0);

    // Character and flush in the same cycle: write then one update.
    bu = n_upd;
    send_char(8'h43, 1'b1);
    wait_idle("char_flush");
    check("char_flush_updates", 32'(n_upd - bu), 32'd1);
    check("char_flush_cursor", 32'(bus.cursor), 32'(exp_cursor()));

    // Randomized text stream against the terminal model.
    do_reset();
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 99) < 70) c = 8'($urandom_range(32, 126));
      else c = ctl[$urandom_range(0, 7)];
      send_char(c, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("rand");
    check("rand_cursor", 32'(bus.cursor), 32'(exp_cursor()));

    // Three flushes during a write merge into one update; reset lands in UPD_WAIT.
    bu = n_upd;
    wr_gate = 1'b0;
    send_char(8'h42, 1'b0);
    repeat (3) begin
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      @(negedge clk);
    end
    push_u();
    wr_gate = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.update_start) found = 1'b1;
    end
    if (!found) fail("flush_update_timeout");
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_pulse", 32'(bus.write_start | bus.update_start), 32'd0);
    end
    check("flush_merge_updates", 32'(n_upd - bu), 32'd1);
    check_reset_vals("midrst");
    row = 0;
    col = 0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_updates", 32'(n_upd - bu), 32'd1);
    check("post_rst_cursor", 32'(bus.cursor), 32'h00);
    check("post_rst_ready", 32'(bus.char_ready), 32'd1);
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
